// File: rtl/regfile.sv
// Two-read / two-write register file with registered read data for a pipelined decode stage.
// Optional macro REGFILE_BYPASS_EN forwards same-edge writes into the sampled read data.
module regfile #(
    parameter int                DATA_W     = 32,
    parameter int                NREGS      = 15,
    parameter logic [DATA_W-1:0] STACK_INIT = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        reg1,
    input  logic [3:0]        reg2,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    input  logic              stall,
    input  logic              weE,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              weM,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam int         RSP   = 4;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  we_e_hit_s;
    logic [NREGS-1:0]  we_m_hit_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] nxt1_s;
    logic [DATA_W-1:0] nxt2_s;

    // Same-edge forwarding of a pending write onto a read address; M port wins over E port.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] stored,
        input logic              we_e,
        input logic [3:0]        dst_e,
        input logic [DATA_W-1:0] val_e,
        input logic              we_m,
        input logic [3:0]        dst_m,
        input logic [DATA_W-1:0] val_m
    );
        logic [DATA_W-1:0] result;
        result = stored;
        if (addr == RNONE) begin
            result = stored;
        end else if (we_m && (dst_m == addr)) begin
            result = val_m;
        end else if (we_e && (dst_e == addr)) begin
            result = val_e;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Per-register write-hit decode for both write ports; RNONE never matches a register.
    always_comb begin
        we_e_hit_s = {NREGS{1'b0}};
        we_m_hit_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            we_e_hit_s[i] = weE && (dstE != RNONE) && (dstE == 4'(i));
            we_m_hit_s[i] = weM && (dstM != RNONE) && (dstM == 4'(i));
        end
    end

    // Register storage: reset dominates, then M port over E port on a shared destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (i == RSP) ? STACK_INIT : {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_m_hit_s[i]) begin
                    regs_r[i] <= valM;
                end else if (we_e_hit_s[i]) begin
                    regs_r[i] <= valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // AND-OR read mux; addresses beyond the array (including RNONE) select nothing and read 0.
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
        rd2_s = {DATA_W{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            rd1_s = rd1_s | (regs_r[i] & {DATA_W{reg1 == 4'(i)}});
            rd2_s = rd2_s | (regs_r[i] & {DATA_W{reg2 == 4'(i)}});
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarded read data; under stall the output register holds, so no bypass is observed.
    always_comb begin
        nxt1_s = bypass(reg1, rd1_s, weE, dstE, valE, weM, dstM, valM);
        nxt2_s = bypass(reg2, rd2_s, weE, dstE, valE, weM, dstM, valM);
    end
`else
    // Plain read data: a same-edge write is seen only on the following read.
    always_comb begin
        nxt1_s = rd1_s;
        nxt2_s = rd2_s;
    end
`endif

    // Registered read ports; stall freezes them while storage keeps accepting writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            val1 <= {DATA_W{1'b0}};
            val2 <= {DATA_W{1'b0}};
        end else if (!stall) begin
            val1 <= nxt1_s;
            val2 <= nxt2_s;
        end else begin
            val1 <= val1;
            val2 <= val2;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven self-checking bench for regfile; each vector is applied for one edge
// and val1/val2 are compared just after that edge.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [3:0]  reg1;
    logic [3:0]  reg2;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        stall;
    logic        weE;
    logic [3:0]  dstE;
    logic [31:0] valE;
    logic        weM;
    logic [3:0]  dstM;
    logic [31:0] valM;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [3:0]  reg1;
        logic [3:0]  reg2;
        logic        we_e;
        logic [3:0]  dst_e;
        logic [31:0] val_e;
        logic        we_m;
        logic [3:0]  dst_m;
        logic [31:0] val_m;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] byp1;
        logic [31:0] byp2;
    } vec_t;

    vec_t vecs[$];

    regfile dut (
        .clk   (clk),
        .rst   (rst),
        .reg1  (reg1),
        .reg2  (reg2),
        .val1  (val1),
        .val2  (val2),
        .stall (stall),
        .weE   (weE),
        .dstE  (dstE),
        .valE  (valE),
        .weM   (weM),
        .dstM  (dstM),
        .valM  (valM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic s, input logic [3:0] r1, input logic [3:0] r2,
        input logic we, input logic [3:0] de, input logic [31:0] ve,
        input logic wm, input logic [3:0] dm, input logic [31:0] vm,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic [31:0] b1, input logic [31:0] b2);
        vec_t v;
        v.rst = r;  v.stall = s; v.reg1 = r1; v.reg2 = r2;
        v.we_e = we; v.dst_e = de; v.val_e = ve;
        v.we_m = wm; v.dst_m = dm; v.val_m = vm;
        v.exp1 = e1; v.exp2 = e2; v.byp1 = b1; v.byp2 = b2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; reg1 = v.reg1; reg2 = v.reg2;
        weE = v.we_e; dstE = v.dst_e; valE = v.val_e;
        weM = v.we_m; dstM = v.dst_m; valM = v.val_m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        drive(mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0));

        //          rst   stall r1     r2     weE   dstE   valE          weM   dstM   valM          exp1          exp2          byp1          byp2
        vecs.push_back(mk(1'b1, 1'b0, 4'h4, 4'h0, 1'b1, 4'h5, 32'h0000_0099, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h100,      32'h0,        32'h100,      32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h3, 4'h4, 1'b1, 4'h3, 32'h0000_1234, 1'b0, 4'h0, 32'h0,         32'h0,        32'h100,      32'h1234,     32'h100));
        vecs.push_back(mk(1'b0, 1'b0, 4'h3, 4'h3, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h1234,     32'h1234,     32'h1234,     32'h1234));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h4, 32'h0000_AAAA, 1'b1, 4'h4, 32'h0000_5555, 32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h4, 4'h3, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h5555,     32'h1234,     32'h5555,     32'h1234));
        vecs.push_back(mk(1'b0, 1'b0, 4'h2, 4'hF, 1'b1, 4'h2, 32'h0000_0077, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h77,       32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h77,       32'h77,       32'h77,       32'h77));
        vecs.push_back(mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 32'h0000_DEAD, 1'b1, 4'hF, 32'h0000_BEEF, 32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h1, 4'h4, 1'b1, 4'h1, 32'h0000_0009, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h1, 4'hE, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h9,        32'h0,        32'h9,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h8, 4'h9, 1'b1, 4'h8, 32'h0000_8888, 1'b1, 4'h9, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'h8888,     32'hFFFF_FFFF));
        vecs.push_back(mk(1'b0, 1'b0, 4'h8, 4'h9, 1'b0, 4'h6, 32'h0000_0055, 1'b0, 4'h0, 32'h0,         32'h8888,     32'hFFFF_FFFF, 32'h8888,    32'hFFFF_FFFF));
        vecs.push_back(mk(1'b0, 1'b0, 4'h6, 4'hE, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'hA, 4'hA, 1'b1, 4'hA, 32'h0000_0001, 1'b1, 4'hA, 32'h0000_0002, 32'h0,        32'h0,        32'h2,        32'h2));
        vecs.push_back(mk(1'b0, 1'b0, 4'h5, 4'hA, 1'b0, 4'h0, 32'h0,         1'b1, 4'h5, 32'h0000_0042, 32'h0,        32'h2,        32'h42,       32'h2));
        vecs.push_back(mk(1'b1, 1'b0, 4'h5, 4'h5, 1'b1, 4'h5, 32'h0000_0099, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h5, 4'h4, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,        32'h100,      32'h0,        32'h100));
        vecs.push_back(mk(1'b0, 1'b0, 4'h8, 4'h4, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,        32'h100,      32'h0,        32'h100));
        vecs.push_back(mk(1'b1, 1'b1, 4'h4, 4'h4, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h100,      32'h100,      32'h100,      32'h100));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
`ifdef REGFILE_BYPASS_EN
            check($sformatf("vec%0d_val1", i), val1, vecs[i].byp1);
            check($sformatf("vec%0d_val2", i), val2, vecs[i].byp2);
`else
            check($sformatf("vec%0d_val1", i), val1, vecs[i].exp1);
            check($sformatf("vec%0d_val2", i), val2, vecs[i].exp2);
`endif
        end

        // Multi-cycle stall: outputs hold across several edges while writes land underneath.
        drive(mk(1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0));
        step();
        check("stall_pre_val1", val1, 32'h0000_0100);
        check("stall_pre_val2", val2, 32'h0000_0000);
        drive(mk(1'b0, 1'b1, 4'hE, 4'hE, 1'b0, 4'h0, 32'h0, 1'b1, 4'hE, 32'h0000_CAFE,
                 32'h0, 32'h0, 32'h0, 32'h0));
        step();
        check("stall1_val1", val1, 32'h0000_0100);
        check("stall1_val2", val2, 32'h0000_0000);
        drive(mk(1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 4'h0, 32'h8000_0001, 1'b0, 4'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0));
        step();
        check("stall2_val1", val1, 32'h0000_0100);
        check("stall2_val2", val2, 32'h0000_0000);
        drive(mk(1'b0, 1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0));
        step();
        check("post_stall_val1", val1, 32'h0000_CAFE);
        check("post_stall_val2", val2, 32'h8000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_W, 32, width of every register and data port.
REQ-002 Parameter: NREGS, 15, architectural registers, indices 0x0-0xE; index 0xF is RNONE.
REQ-003 Parameter: STACK_INIT, 32'h0000_0100, reset value of register 0x4 (%rsp).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: reg1  input  4  read address, port 1 (decode's valA source).
REQ-008 Port: reg2  input  4  read address, port 2 (decode's valB source).
REQ-009 Port: val1  output  DATA_W  registered read data, port 1.
REQ-010 Port: val2  output  DATA_W  registered read data, port 2.
REQ-011 Port: stall  input  1  high: val1/val2 hold; writes still occur.
REQ-012 Port: weE  input  1  write enable, E port (ALU result).
REQ-013 Port: dstE  input  4  write address, E port.
REQ-014 Port: valE  input  DATA_W  write data, E port.
REQ-015 Port: weM  input  1  write enable, M port (memory result).
REQ-016 Port: dstM  input  4  write address, M port.
REQ-017 Port: valM  input  DATA_W  write data, M port.

Function
REQ-018 Storage is NREGS x DATA_W flops; no combinational path from any input to val1/val2.
REQ-019 Read latency is one cycle: with stall low, val1/val2 at edge N+1 reflect reg1/reg2 sampled at edge N.
REQ-020 A read of address 0xF returns 0.
REQ-021 A write with weX high and dstX = 0xF is discarded; the write with weX low is discarded.
REQ-022 A write takes effect at the rising edge where weX is high; DATA_W bits are stored unmodified.
REQ-023 When weE and weM both target the same register on the same edge, valM is stored and valE is discarded.
REQ-024 Writes to different registers on the same edge both take effect.
REQ-025 When stall is high, val1/val2 keep their previous values, reg1/reg2 are ignored, and writes proceed normally.
REQ-026 When reg1 = reg2, val1 = val2.
REQ-027 Without bypass (see Configuration), a read sampled on the same edge as a write to that address returns the pre-write value.

Reset
REQ-028 While rst is high at a rising edge, registers 0x0-0xE except 0x4 are set to 0, register 0x4 to STACK_INIT, and val1/val2 to 0.
REQ-029 Reset has priority over writes and stall; writes presented during a reset edge are discarded.
REQ-030 The first edge after rst deasserts performs normal reads/writes; there is no recovery latency.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN: when defined, a read sampled on an edge with a same-address write returns the written value (valM when both ports hit; the rule in REQ-023 applies); bypass is skipped for address 0xF and while stall is high.
REQ-032 When REGFILE_BYPASS_EN is undefined, no bypass logic exists and REQ-027 applies.

Verification
REQ-033 rst=1 for one edge, then reg1=0x4, reg2=0x0 -> next edge val1=0x100, val2=0.
REQ-034 weE=1, dstE=0x3, valE=0x1234, then reg1=0x3 on a later edge -> val1=0x1234 one cycle after that.
REQ-035 weE=1 dstE=0x4 valE=0xAAAA and weM=1 dstM=0x4 valM=0x5555 on one edge, then read 0x4 -> 0x5555.
REQ-036 weE=1 dstE=0x2 valE=0x77 on the same edge as reg1=0x2 -> val1=0x77 with REGFILE_BYPASS_EN defined, old value (0) without it.
REQ-037 Write 0xF with 0xDEAD, read reg2=0xF -> val2=0; stall=1 while writing 0x1=0x9 -> val1/val2 unchanged, later read of 0x1 returns 0x9.
REQ-038 Write 0x5=0x42, assert rst mid-run alongside weE to 0x5=0x99 -> read of 0x5 returns 0.
